// File: rtl/dreq_queue_unit.sv
// Data-memory request queue: buffers pipeline load/store requests in a
// DEPTH-entry circular FIFO and issues them to memory one at a time.
module dreq_queue_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dren,
  input  logic              dwen,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  input  logic              flush,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dload,
  output logic              dmemren,
  output logic              dmemwen,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              full,
  output logic              empty,
  output logic              stall,
  output logic              spurious
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);

  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [PW:0]       r_count;
  logic              r_wen  [DEPTH];
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic              r_rdata_valid;
  logic              r_spurious;

  logic w_empty;
  logic w_full;
  logic w_req;
  logic w_push;
  logic w_pop;
  logic w_head_wen;

  always_comb begin
    w_empty    = (r_count == '0);
    w_full     = (r_count == CNT_FULL);
    w_req      = ihit & (dren | dwen);
    w_push     = w_req & ~w_full & ~flush;
    w_pop      = dhit & ~w_empty;
    w_head_wen = r_wen[r_head];
  end

  // Head fields are masked while empty so unreset storage never reaches the bus
  assign dmemren     = ~w_empty & ~w_head_wen;
  assign dmemwen     = ~w_empty & w_head_wen;
  assign dmemaddr    = w_empty ? '0 : r_addr[r_head];
  assign dmemstore   = w_empty ? '0 : r_data[r_head];
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign full        = w_full;
  assign empty       = w_empty;
  assign stall       = w_req & w_full;
  assign spurious    = r_spurious;

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_wen[r_tail]  <= dwen;
      r_addr[r_tail] <= daddr;
      r_data[r_tail] <= dstore;
    end
  end

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_spurious    <= 1'b0;
    end else begin
      if (w_pop) r_head <= r_head + 1'b1;
      // Flush keeps only the (possibly in-flight) head entry
      if (flush) begin
        if (!w_empty) r_tail <= r_head + 1'b1;
        r_count <= (w_empty || w_pop) ? '0 : CNT_ONE;
      end else begin
        if (w_push) r_tail <= r_tail + 1'b1;
        r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
      end
      r_rdata_valid <= w_pop & ~w_head_wen;
      if (w_pop && !w_head_wen) r_rdata <= dload;
      if (dhit && w_empty) r_spurious <= 1'b1;
    end
  end

endmodule
